uart_in_source: RTL and testbench

UART_IN_SOURCE -- requirements
Module: uart_in_source

---
 rtl/uart_in_pkg.sv | 13 +
 rtl/char_fifo.sv | 46 ++++
 rtl/uart_in_source.sv | 83 ++++++++
 tb/tb_uart_in_source.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_in_pkg.sv
// Shared widths, defaults and helpers for the UART console input source.
package uart_in_pkg;
    localparam int CHAR_W = 8;
    localparam int CNT_W  = 32;
    localparam logic [CHAR_W-1:0] EMPTY_CHAR_DEF = 8'hFF;

    typedef logic [CHAR_W-1:0] char_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/char_fifo.sv
// Synchronous character FIFO; head is the oldest entry, level is occupancy.
module char_fifo
    import uart_in_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  char_t       push_data,
    input  logic        pop,
    output char_t       head,
    output logic [AW:0] level
);
    char_t         r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_level;

    always_ff @(posedge clock) begin
        if (reset && push) begin
            r_mem[r_wr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (push) r_wr <= r_wr + 1'b1;
            if (pop)  r_rd <= r_rd + 1'b1;
            unique case ({push, pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign head  = r_mem[r_rd];
    assign level = r_level;
endmodule

// File: rtl/uart_in_source.sv
// Console byte source answering getc requests one cycle later,
// with a minimum spacing between delivered characters.
module uart_in_source
    import uart_in_pkg::*;
#(
    parameter  int    DEPTH      = 16,
    parameter  int    GAP_CYCLES = 8,
    parameter  char_t EMPTY_CHAR = EMPTY_CHAR_DEF,
    localparam int    LW         = $clog2(DEPTH) + 1,
    localparam int    GW         = $clog2(GAP_CYCLES + 2)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_valid,
    input  logic [7:0]    push_data,
    output logic          push_ready,
    input  logic          getc_req,
    output logic          getc_resp_valid,
    output logic [7:0]    getc_ch,
    output logic [LW-1:0] level,
    output logic [31:0]   delivered_count,
    output logic [31:0]   empty_count
);
    logic [GW-1:0] r_gap;
    logic          r_resp_valid;
    char_t         r_ch;
    cnt_t          r_delivered;
    cnt_t          r_empty;

    logic          w_push;
    logic          w_deliver;
    char_t         w_head;
    logic [LW-1:0] w_level;

    // Readiness comes from the registered level, so a pop never frees a slot early.
    assign push_ready = reset && (w_level < LW'(DEPTH));
    assign w_push     = push_valid && push_ready;
    assign w_deliver  = reset && getc_req && (w_level != '0) && (r_gap == '0);

    char_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (w_push),
        .push_data(push_data),
        .pop      (w_deliver),
        .head     (w_head),
        .level    (w_level)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_gap        <= '0;
            r_resp_valid <= 1'b0;
            r_ch         <= '0;
            r_delivered  <= '0;
            r_empty      <= '0;
        end else begin
            r_resp_valid <= getc_req;
            if (getc_req) begin
                if (w_deliver) begin
                    r_ch        <= w_head;
                    r_delivered <= sat_inc(r_delivered);
                end else begin
                    r_ch    <= EMPTY_CHAR;
                    r_empty <= sat_inc(r_empty);
                end
            end
            if (w_deliver) begin
                r_gap <= GW'(GAP_CYCLES);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

    assign getc_resp_valid = r_resp_valid;
    assign getc_ch         = r_ch;
    assign level           = w_level;
    assign delivered_count = r_delivered;
    assign empty_count     = r_empty;
endmodule

// File: tb/tb_uart_in_source.sv
// Bench for uart_in_source: two instances (gap 0 and gap 8) checked against a queue model.
module tb_uart_in_source;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          push_valid;
    logic [7:0]    push_data;
    logic          getc_req;

    logic          rdy0, rv0, rdy1, rv1;
    logic [7:0]    ch0, ch1;
    logic [LW-1:0] lvl0, lvl1;
    logic [31:0]   dc0, ec0, dc1, ec1;

    uart_in_source #(.DEPTH(DEPTH), .GAP_CYCLES(0), .EMPTY_CHAR(8'hFF)) u0 (
        .clock(clock), .reset(reset),
        .push_valid(push_valid), .push_data(push_data), .push_ready(rdy0),
        .getc_req(getc_req), .getc_resp_valid(rv0), .getc_ch(ch0),
        .level(lvl0), .delivered_count(dc0), .empty_count(ec0)
    );

    uart_in_source #(.DEPTH(DEPTH), .GAP_CYCLES(8), .EMPTY_CHAR(8'hFF)) u8 (
        .clock(clock), .reset(reset),
        .push_valid(push_valid), .push_data(push_data), .push_ready(rdy1),
        .getc_req(getc_req), .getc_resp_valid(rv1), .getc_ch(ch1),
        .level(lvl1), .delivered_count(dc1), .empty_count(ec1)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a byte queue per instance plus the cycle of the last delivery.
    logic [7:0] mq [2][$];
    int         mlast [2];
    int         mcyc;
    bit         mrst;
    bit         mrv [2];
    logic [7:0] mch [2];
    int         mdc [2];
    int         mec [2];

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 8;
    endfunction

    task automatic model_step(input bit r, input bit pv, input logic [7:0] pd, input bit rq);
        for (int d = 0; d < 2; d++) begin
            bit pre_rdy;
            pre_rdy = r && (mq[d].size() < DEPTH);
            if (!r) begin
                mq[d].delete();
                mlast[d] = -1;
                mrv[d]   = 1'b0;
                mch[d]   = 8'h00;
                mdc[d]   = 0;
                mec[d]   = 0;
            end else begin
                mrv[d] = rq;
                if (rq) begin
                    if (mq[d].size() > 0 &&
                        (mlast[d] < 0 || mcyc - mlast[d] > gap_of(d))) begin
                        mch[d]   = mq[d].pop_front();
                        mdc[d]   = mdc[d] + 1;
                        mlast[d] = mcyc;
                    end else begin
                        mch[d] = 8'hFF;
                        mec[d] = mec[d] + 1;
                    end
                end
                if (pv && pre_rdy) mq[d].push_back(pd);
            end
        end
        mrst = r;
        mcyc++;
    endtask

    task automatic check_model();
        chk($sformatf("c%0d u0.resp_valid", mcyc), 64'(rv0), 64'(mrv[0]));
        chk($sformatf("c%0d u0.ch", mcyc), 64'(ch0), 64'(mch[0]));
        chk($sformatf("c%0d u0.level", mcyc), 64'(lvl0), 64'(mq[0].size()));
        chk($sformatf("c%0d u0.ready", mcyc), 64'(rdy0),
            64'(mrst && mq[0].size() < DEPTH));
        chk($sformatf("c%0d u0.delivered", mcyc), 64'(dc0), 64'(mdc[0]));
        chk($sformatf("c%0d u0.empty", mcyc), 64'(ec0), 64'(mec[0]));
        chk($sformatf("c%0d u8.resp_valid", mcyc), 64'(rv1), 64'(mrv[1]));
        chk($sformatf("c%0d u8.ch", mcyc), 64'(ch1), 64'(mch[1]));
        chk($sformatf("c%0d u8.level", mcyc), 64'(lvl1), 64'(mq[1].size()));
        chk($sformatf("c%0d u8.ready", mcyc), 64'(rdy1),
            64'(mrst && mq[1].size() < DEPTH));
        chk($sformatf("c%0d u8.delivered", mcyc), 64'(dc1), 64'(mdc[1]));
        chk($sformatf("c%0d u8.empty", mcyc), 64'(ec1), 64'(mec[1]));
    endtask

    task automatic step(input bit r, input bit pv, input logic [7:0] pd, input bit rq);
        reset      = r;
        push_valid = pv;
        push_data  = pd;
        getc_req   = rq;
        model_step(r, pv, pd, rq);
        @(posedge clock);
        #1;
        check_model();
    endtask

    typedef struct {
        bit         pv;
        logic [7:0] pd;
        bit         rq;
        bit         erv;
        logic [7:0] ech;
        int         elvl;
    } vec_t;

    vec_t       tbl [10];
    logic [7:0] got [$];

    initial begin
        reset      = 1'b0;
        push_valid = 1'b0;
        push_data  = 8'h00;
        getc_req   = 1'b0;
        mcyc       = 0;
        mrst       = 1'b0;
        for (int d = 0; d < 2; d++) mlast[d] = -1;

        // Expected values for the gap-0 instance after each edge.
        tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1};
        tbl[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 2};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 0};
        tbl[7] = '{1'b1, 8'h5A, 1'b1, 1'b1, 8'hFF, 1};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 0};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 0};

        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h33, 1'b1);
        chk("reset ch", 64'(ch0), 64'h00);
        chk("reset resp_valid", 64'(rv0), 64'h0);
        chk("reset level", 64'(lvl0), 64'h0);
        chk("reset ready", 64'(rdy0), 64'h0);
        chk("reset delivered", 64'(dc0), 64'h0);
        reset = 1'b1;
        #1;
        chk("ready after release", 64'(rdy0), 64'h1);

        for (int i = 0; i < 10; i++) begin
            step(1'b1, tbl[i].pv, tbl[i].pd, tbl[i].rq);
            chk($sformatf("vec%0d resp_valid", i), 64'(rv0), 64'(tbl[i].erv));
            chk($sformatf("vec%0d ch", i), 64'(ch0), 64'(tbl[i].ech));
            chk($sformatf("vec%0d level", i), 64'(lvl0), 64'(tbl[i].elvl));
        end
        chk("vec delivered_count", 64'(dc0), 64'd3);
        chk("vec empty_count", 64'(ec0), 64'd4);

        // Gap rule on the gap-8 instance.
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h11, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1);
            chk($sformatf("gap resp%0d", i), 64'(ch1),
                64'((i == 0) ? 8'h11 : (i == 9) ? 8'h22 : 8'hFF));
            chk($sformatf("gap strobe%0d", i), 64'(rv1), 64'h1);
        end

        // Full FIFO and pointer wrap on the gap-0 instance.
        step(1'b0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 8'(8'h40 + k), 1'b0);
        chk("full ready", 64'(rdy0), 64'h0);
        chk("full level", 64'(lvl0), 64'd16);
        got.delete();
        step(1'b1, 1'b1, 8'hEE, 1'b1);
        chk("full pop level", 64'(lvl0), 64'd15);
        if (rv0 && ch0 != 8'hFF) got.push_back(ch0);
        for (int k = 16; k < 20; k++) begin
            step(1'b1, 1'b1, 8'(8'h40 + k), 1'b1);
            if (rv0 && ch0 != 8'hFF) got.push_back(ch0);
        end
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1);
            if (rv0 && ch0 != 8'hFF) got.push_back(ch0);
        end
        chk("wrap count", 64'(got.size()), 64'd20);
        for (int k = 0; k < 20 && k < got.size(); k++)
            chk($sformatf("wrap order%0d", k), 64'(got[k]), 64'(8'h40 + k));

        // Reset while bytes are queued and a request is raised.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 8'(8'h60 + k), 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("midreset strobe", 64'(rv0), 64'h0);
        chk("midreset level", 64'(lvl0), 64'h0);
        chk("midreset delivered", 64'(dc0), 64'h0);
        chk("midreset empty", 64'(ec0), 64'h0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("after reset ch", 64'(ch0), 64'hFF);
        chk("after reset strobe", 64'(rv0), 64'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 199) != 0, $urandom_range(0, 2) != 0,
                 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
